// File: rtl/lbuf_sched_pkg.sv
// Shared types for the large-buffer scheduler: FSM encoding, buffer indices, descriptor widths.
// Used by the host-control block, receive DMA engine and completion writer.
package lbuf_sched_pkg;

    localparam int ADDR_W = 64;
    localparam int LEN_W  = 32;

    localparam logic LBUF1_IDX = 1'b0;
    localparam logic LBUF2_IDX = 1'b1;

    typedef enum logic [4:0] {
        ST_IDLE    = 5'b00001,
        ST_OFFER   = 5'b00010,
        ST_BUSY    = 5'b00100,
        ST_NOTIFY  = 5'b01000,
        ST_RELEASE = 5'b10000
    } state_t;

    // The engine may report more bytes than the buffer holds; never report past its end.
    function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] bytes,
                                                   input logic [LEN_W-1:0] len);
        return (bytes < len) ? bytes : len;
    endfunction

endpackage

// File: rtl/lbuf_desc_mux.sv
// 2:1 descriptor select between the two host-posted buffers, keyed on the current index.
// Purely combinational, no backpressure.
module lbuf_desc_mux
    import lbuf_sched_pkg::*;
(
    input  logic              sel,
    input  logic [ADDR_W-1:0] lbuf1_addr,
    input  logic [LEN_W-1:0]  lbuf1_len,
    input  logic              lbuf1_en,
    input  logic [ADDR_W-1:0] lbuf2_addr,
    input  logic [LEN_W-1:0]  lbuf2_len,
    input  logic              lbuf2_en,
    output logic [ADDR_W-1:0] sel_addr,
    output logic [LEN_W-1:0]  sel_len,
    output logic              sel_en
);

    assign sel_addr = (sel == LBUF2_IDX) ? lbuf2_addr : lbuf1_addr;
    assign sel_len  = (sel == LBUF2_IDX) ? lbuf2_len  : lbuf1_len;
    assign sel_en   = (sel == LBUF2_IDX) ? lbuf2_en   : lbuf1_en;

endmodule

// File: rtl/lbuf_sched.sv
// Ping-pong scheduler handing lbuf1/lbuf2 to the RX DMA engine in strict alternation.
// All outputs registered; stalls indefinitely on dma_ack / cpl_ack with offer and completion held stable.
module lbuf_sched
    import lbuf_sched_pkg::*;
#(
    parameter int SEQ_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lbuf1_addr,
    input  logic [LEN_W-1:0]  lbuf1_len,
    input  logic              lbuf1_en,
    output logic              lbuf1_dn,
    input  logic [ADDR_W-1:0] lbuf2_addr,
    input  logic [LEN_W-1:0]  lbuf2_len,
    input  logic              lbuf2_en,
    output logic              lbuf2_dn,
    output logic [ADDR_W-1:0] dma_addr,
    output logic [LEN_W-1:0]  dma_len,
    output logic              dma_valid,
    input  logic              dma_ack,
    input  logic              dma_done,
    input  logic [LEN_W-1:0]  dma_bytes,
    output logic              cpl_req,
    input  logic              cpl_ack,
    output logic              cpl_idx,
    output logic [LEN_W-1:0]  cpl_bytes,
    output logic [SEQ_W-1:0]  cpl_seq,
    output logic              active_idx
);

    state_t             state_q, state_d;
    logic               cur_q, cur_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [ADDR_W-1:0]  dma_addr_q, dma_addr_d;
    logic [LEN_W-1:0]   dma_len_q, dma_len_d;
    logic               dma_valid_q, dma_valid_d;
    logic               cpl_req_q, cpl_req_d;
    logic               cpl_idx_q, cpl_idx_d;
    logic [LEN_W-1:0]   cpl_bytes_q, cpl_bytes_d;
    logic [SEQ_W-1:0]   cpl_seq_q, cpl_seq_d;
    logic               dn1_q, dn1_d;
    logic               dn2_q, dn2_d;

    logic [ADDR_W-1:0]  sel_addr;
    logic [LEN_W-1:0]   sel_len;
    logic               sel_en;

    lbuf_desc_mux u_desc_mux (
        .sel        (cur_q),
        .lbuf1_addr (lbuf1_addr),
        .lbuf1_len  (lbuf1_len),
        .lbuf1_en   (lbuf1_en),
        .lbuf2_addr (lbuf2_addr),
        .lbuf2_len  (lbuf2_len),
        .lbuf2_en   (lbuf2_en),
        .sel_addr   (sel_addr),
        .sel_len    (sel_len),
        .sel_en     (sel_en)
    );

    // Pulse-type outputs are computed for the state being entered so they appear
    // registered in the same cycle the FSM occupies that state.
    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        seq_d       = seq_q;
        dma_addr_d  = dma_addr_q;
        dma_len_d   = dma_len_q;
        cpl_idx_d   = cpl_idx_q;
        cpl_bytes_d = cpl_bytes_q;
        cpl_seq_d   = cpl_seq_q;
        dma_valid_d = 1'b0;
        cpl_req_d   = 1'b0;
        dn1_d       = 1'b0;
        dn2_d       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_en) begin
                    dma_addr_d = sel_addr;
                    dma_len_d  = sel_len;
                    if (sel_len != '0) begin
                        state_d     = ST_OFFER;
                        dma_valid_d = 1'b1;
                    end else begin
                        state_d = ST_RELEASE;
                        dn1_d   = (cur_q == LBUF1_IDX);
                        dn2_d   = (cur_q == LBUF2_IDX);
                    end
                end
            end
            ST_OFFER: begin
                if (dma_ack) begin
                    state_d = ST_BUSY;
                end else begin
                    dma_valid_d = 1'b1;
                end
            end
            ST_BUSY: begin
                if (dma_done) begin
                    state_d     = ST_NOTIFY;
                    cpl_req_d   = 1'b1;
                    cpl_idx_d   = cur_q;
                    cpl_seq_d   = seq_q;
                    cpl_bytes_d = clamp_len(dma_bytes, dma_len_q);
                end
            end
            ST_NOTIFY: begin
                if (cpl_ack) begin
                    state_d = ST_RELEASE;
                    seq_d   = seq_q + SEQ_W'(1);
                    dn1_d   = (cur_q == LBUF1_IDX);
                    dn2_d   = (cur_q == LBUF2_IDX);
                end else begin
                    cpl_req_d = 1'b1;
                end
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
                cur_d   = ~cur_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_q       <= LBUF1_IDX;
            seq_q       <= '0;
            dma_addr_q  <= '0;
            dma_len_q   <= '0;
            dma_valid_q <= 1'b0;
            cpl_req_q   <= 1'b0;
            cpl_idx_q   <= LBUF1_IDX;
            cpl_bytes_q <= '0;
            cpl_seq_q   <= '0;
            dn1_q       <= 1'b0;
            dn2_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            seq_q       <= seq_d;
            dma_addr_q  <= dma_addr_d;
            dma_len_q   <= dma_len_d;
            dma_valid_q <= dma_valid_d;
            cpl_req_q   <= cpl_req_d;
            cpl_idx_q   <= cpl_idx_d;
            cpl_bytes_q <= cpl_bytes_d;
            cpl_seq_q   <= cpl_seq_d;
            dn1_q       <= dn1_d;
            dn2_q       <= dn2_d;
        end
    end

    assign lbuf1_dn   = dn1_q;
    assign lbuf2_dn   = dn2_q;
    assign dma_addr   = dma_addr_q;
    assign dma_len    = dma_len_q;
    assign dma_valid  = dma_valid_q;
    assign cpl_req    = cpl_req_q;
    assign cpl_idx    = cpl_idx_q;
    assign cpl_bytes  = cpl_bytes_q;
    assign cpl_seq    = cpl_seq_q;
    assign active_idx = cur_q;

endmodule

// File: tb/tb_lbuf_sched.sv
// Bench for lbuf_sched: table of buffers served through behavioural DMA / completion responders,
// with queued expectations for offers, completions and dn pulses, plus hand-written ordering and reset sequences.
`timescale 1ns/1ps
module tb_lbuf_sched;

    localparam int SEQ_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [63:0]       lbuf1_addr, lbuf2_addr;
    logic [31:0]       lbuf1_len, lbuf2_len;
    logic              lbuf1_en, lbuf2_en;
    logic              lbuf1_dn, lbuf2_dn;
    logic [63:0]       dma_addr;
    logic [31:0]       dma_len;
    logic              dma_valid, dma_ack, dma_done;
    logic [31:0]       dma_bytes;
    logic              cpl_req, cpl_ack, cpl_idx;
    logic [31:0]       cpl_bytes;
    logic [SEQ_W-1:0]  cpl_seq;
    logic              active_idx;

    always #5 clk = ~clk;

    lbuf_sched #(.SEQ_W(SEQ_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .lbuf1_addr (lbuf1_addr),
        .lbuf1_len  (lbuf1_len),
        .lbuf1_en   (lbuf1_en),
        .lbuf1_dn   (lbuf1_dn),
        .lbuf2_addr (lbuf2_addr),
        .lbuf2_len  (lbuf2_len),
        .lbuf2_en   (lbuf2_en),
        .lbuf2_dn   (lbuf2_dn),
        .dma_addr   (dma_addr),
        .dma_len    (dma_len),
        .dma_valid  (dma_valid),
        .dma_ack    (dma_ack),
        .dma_done   (dma_done),
        .dma_bytes  (dma_bytes),
        .cpl_req    (cpl_req),
        .cpl_ack    (cpl_ack),
        .cpl_idx    (cpl_idx),
        .cpl_bytes  (cpl_bytes),
        .cpl_seq    (cpl_seq),
        .active_idx (active_idx)
    );

    typedef struct {
        logic             idx;
        logic [63:0]      addr;
        logic [31:0]      len;
        int               ack_dly;
        int               cpl_dly;
        logic [31:0]      bytes;
        logic [31:0]      exp_bytes;
        logic [SEQ_W-1:0] exp_seq;
    } vec_t;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] len;
    } offer_t;

    typedef struct {
        logic             idx;
        logic [31:0]      bytes;
        logic [SEQ_W-1:0] seq;
    } cpl_t;

    offer_t offer_q[$];
    cpl_t   cpl_q[$];
    logic   dn_q[$];
    vec_t   vecs[7];

    int checks = 0;
    int errors = 0;

    bit          auto_en;
    int          ack_dly, cpl_dly, done_dly;
    int          ack_cnt, cpl_cnt, busy_cnt;
    bit          busy, hs_dma, dn_seen;
    logic [31:0] bytes_val;
    bit          prev_ok;
    logic        prev_valid, prev_ack, prev_req, prev_cack, prev_dn;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
        end
    endtask

    // Sampled on the falling edge: scoreboard pops and protocol checks.
    task automatic sample();
        hs_dma = 1'b0;
        if (rst) begin
            prev_ok = 1'b0;
            return;
        end
        if (prev_ok && prev_valid && !prev_ack) chk("offer_held", dma_valid, 1);
        if (prev_ok && prev_req && !prev_cack)  chk("cpl_req_held", cpl_req, 1);
        if (dma_valid) begin
            chk("offer_expected", offer_q.size() != 0, 1);
            if (offer_q.size() != 0) begin
                chk("offer_addr", dma_addr, offer_q[0].addr);
                chk("offer_len", dma_len, offer_q[0].len);
                if (dma_ack) offer_q.delete(0);
            end
            hs_dma = dma_ack;
        end
        if (cpl_req) begin
            chk("cpl_expected", cpl_q.size() != 0, 1);
            if (cpl_q.size() != 0) begin
                chk("cpl_idx", cpl_idx, cpl_q[0].idx);
                chk("cpl_bytes", cpl_bytes, cpl_q[0].bytes);
                chk("cpl_seq", cpl_seq, cpl_q[0].seq);
                if (cpl_ack) cpl_q.delete(0);
            end
        end
        if (lbuf1_dn || lbuf2_dn) begin
            dn_seen = 1'b1;
            chk("dn_onehot", lbuf1_dn & lbuf2_dn, 0);
            chk("dn_single_cycle", prev_ok & prev_dn, 0);
            chk("dn_after_cpl", cpl_q.size(), 0);
            chk("dn_expected", dn_q.size() != 0, 1);
            if (dn_q.size() != 0) begin
                chk("dn_idx", lbuf2_dn, dn_q[0]);
                dn_q.delete(0);
            end
        end
        prev_valid = dma_valid;
        prev_ack   = dma_ack;
        prev_req   = cpl_req;
        prev_cack  = cpl_ack;
        prev_dn    = lbuf1_dn | lbuf2_dn;
        prev_ok    = 1'b1;
    endtask

    // Behavioural DMA engine and completion writer, driven just after the rising edge.
    task automatic respond();
        if (!auto_en) return;
        if (hs_dma) begin
            busy     = 1'b1;
            busy_cnt = 0;
        end
        dma_done = 1'b0;
        if (busy) begin
            if (busy_cnt >= done_dly) begin
                dma_done  = 1'b1;
                dma_bytes = bytes_val;
                busy      = 1'b0;
            end else begin
                busy_cnt++;
            end
        end
        if (dma_valid) begin
            dma_ack = (ack_cnt >= ack_dly);
            ack_cnt++;
        end else begin
            dma_ack = 1'b0;
            ack_cnt = 0;
        end
        if (cpl_req) begin
            cpl_ack = (cpl_cnt >= cpl_dly);
            cpl_cnt++;
        end else begin
            cpl_ack = 1'b0;
            cpl_cnt = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        respond();
    endtask

    task automatic chk_reset();
        chk("rst_dma_valid", dma_valid, 0);
        chk("rst_cpl_req", cpl_req, 0);
        chk("rst_lbuf1_dn", lbuf1_dn, 0);
        chk("rst_lbuf2_dn", lbuf2_dn, 0);
        chk("rst_active_idx", active_idx, 0);
        chk("rst_cpl_idx", cpl_idx, 0);
        chk("rst_cpl_seq", cpl_seq, 0);
        chk("rst_dma_addr", dma_addr, 0);
        chk("rst_dma_len", dma_len, 0);
        chk("rst_cpl_bytes", cpl_bytes, 0);
    endtask

    task automatic serve(input vec_t v);
        ack_dly   = v.ack_dly;
        cpl_dly   = v.cpl_dly;
        bytes_val = v.bytes;
        dn_seen   = 1'b0;
        if (v.idx == 1'b0) begin
            lbuf1_addr = v.addr;
            lbuf1_len  = v.len;
            lbuf1_en   = 1'b1;
        end else begin
            lbuf2_addr = v.addr;
            lbuf2_len  = v.len;
            lbuf2_en   = 1'b1;
        end
        if (v.len != 0) begin
            offer_q.push_back('{v.addr, v.len});
            cpl_q.push_back('{v.idx, v.exp_bytes, v.exp_seq});
        end
        dn_q.push_back(v.idx);
        step();
        if (v.len != 0) begin
            chk("offer_latency", dma_valid, 1);
            chk("offer_latch_addr", dma_addr, v.addr);
        end else begin
            chk("zero_len_dn", (v.idx == 1'b0) ? lbuf1_dn : lbuf2_dn, 1);
            chk("zero_len_no_valid", dma_valid, 0);
            chk("zero_len_no_req", cpl_req, 0);
        end
        for (int i = 0; i < 400 && !dn_seen; i++) step();
        chk("dn_seen", dn_seen, 1);
        if (v.idx == 1'b0) lbuf1_en = 1'b0;
        else               lbuf2_en = 1'b0;
        chk("active_idx_toggle", active_idx, !v.idx);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        lbuf1_addr = '0; lbuf1_len = '0; lbuf1_en = 1'b0;
        lbuf2_addr = '0; lbuf2_len = '0; lbuf2_en = 1'b0;
        dma_ack = 1'b0; dma_done = 1'b0; dma_bytes = '0; cpl_ack = 1'b0;
        auto_en = 1'b1; ack_dly = 0; cpl_dly = 0; done_dly = 1;
        ack_cnt = 0; cpl_cnt = 0; busy_cnt = 0; busy = 1'b0; bytes_val = '0;
        hs_dma = 1'b0; dn_seen = 1'b0; prev_ok = 1'b0;
        prev_valid = 1'b0; prev_ack = 1'b0; prev_req = 1'b0; prev_cack = 1'b0; prev_dn = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk_reset();

        //         idx   addr                    len           ack cpl bytes         exp_bytes     seq
        vecs[0] = '{1'b0, 64'h0000_0001_0000_0000, 32'h0000_1000, 2,  0, 32'h0000_0800, 32'h0000_0800, 2'd0};
        vecs[1] = '{1'b1, 64'h0000_0001_0000_8000, 32'h0000_2000, 0,  0, 32'h0000_2000, 32'h0000_2000, 2'd1};
        vecs[2] = '{1'b0, 64'h0000_0002_0000_0000, 32'h0000_0100, 1,  0, 32'h0000_0200, 32'h0000_0100, 2'd2};
        vecs[3] = '{1'b1, 64'h0000_0002_0000_1000, 32'h0000_0000, 0,  0, 32'h0000_0000, 32'h0000_0000, 2'd0};
        vecs[4] = '{1'b0, 64'hffff_ffff_ffff_f000, 32'h0000_0040, 50, 30, 32'h0000_003c, 32'h0000_003c, 2'd3};
        vecs[5] = '{1'b1, 64'h0000_0003_0000_0000, 32'hffff_ffff, 0,  3, 32'h1234_5678, 32'h1234_5678, 2'd0};
        vecs[6] = '{1'b0, 64'h0000_0003_0001_0000, 32'h0000_0010, 0,  0, 32'hffff_ffff, 32'h0000_0010, 2'd1};
        for (int i = 0; i < 7; i++) serve(vecs[i]);

        // Ordering: lbuf2 posted early must wait for lbuf1, then follows with minimum turnaround.
        rst = 1'b1;
        step();
        rst = 1'b0;
        busy = 1'b0;
        chk_reset();
        ack_dly = 0;
        cpl_dly = 0;
        lbuf2_addr = 64'h0000_0004_0000_0000;
        lbuf2_len  = 32'h300;
        lbuf2_en   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("ordering_no_offer", dma_valid, 0);
        end
        serve('{1'b0, 64'h0000_0005_0000_0000, 32'h400, 0, 0, 32'h400, 32'h400, 2'd0});
        chk("turnaround_gap", dma_valid, 0);
        serve('{1'b1, 64'h0000_0004_0000_0000, 32'h300, 0, 0, 32'h123, 32'h123, 2'd1});

        // Reset while BUSY aborts the buffer without dn or completion.
        done_dly   = 1000;
        ack_dly    = 0;
        lbuf1_addr = 64'h0000_0006_0000_0000;
        lbuf1_len  = 32'h200;
        lbuf1_en   = 1'b1;
        offer_q.push_back('{64'h0000_0006_0000_0000, 32'h200});
        for (int i = 0; i < 4; i++) step();
        chk("busy_no_valid", dma_valid, 0);
        chk("busy_no_req", cpl_req, 0);
        auto_en  = 1'b0;
        busy     = 1'b0;
        dma_ack  = 1'b0;
        cpl_ack  = 1'b0;
        dma_done = 1'b0;
        rst      = 1'b1;
        lbuf1_en = 1'b0;
        step();
        rst = 1'b0;
        chk_reset();
        dma_done  = 1'b1;
        dma_bytes = 32'h55;
        step();
        dma_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stray_done_no_req", cpl_req, 0);
            chk("stray_done_no_valid", dma_valid, 0);
        end
        auto_en    = 1'b1;
        done_dly   = 1;
        lbuf2_addr = 64'h0000_0007_0000_0000;
        lbuf2_len  = 32'h80;
        lbuf2_en   = 1'b1;
        serve('{1'b0, 64'h0000_0008_0000_0000, 32'h100, 0, 0, 32'h100, 32'h100, 2'd0});
        serve('{1'b1, 64'h0000_0007_0000_0000, 32'h80,  0, 0, 32'h7f,  32'h7f,  2'd1});

        step();
        chk("offer_q_drained", offer_q.size(), 0);
        chk("cpl_q_drained", cpl_q.size(), 0);
        chk("dn_q_drained", dn_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lbuf_sched.md
# lbuf_sched

Ping-pong scheduler between the host-control register block and the receive DMA engine. It takes the two host-posted large buffers (lbuf1/lbuf2: address, length, enable) and hands them to the DMA engine one at a time in strict alternation, starting with lbuf1. After the engine fills a buffer, the block requests a completion notification and then returns the buffer to the host-control block with a one-cycle done pulse.

## Interface
- `SEQ_W`, 16: width of the buffer sequence counter reported with each completion.
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `lbuf1_addr` in 64: host bus address of buffer 1.
- `lbuf1_len` in 32: length of buffer 1, in bytes.
- `lbuf1_en` in 1: buffer 1 posted; level held until `lbuf1_dn`.
- `lbuf1_dn` out 1: one-cycle pulse; returns buffer 1.
- `lbuf2_addr`, `lbuf2_len`, `lbuf2_en`, `lbuf2_dn`: same as the buffer 1 signals, for buffer 2.
- `dma_addr` out 64: address of the offered buffer.
- `dma_len` out 32: length of the offered buffer.
- `dma_valid` out 1: buffer offered to the DMA engine.
- `dma_ack` in 1: engine accepts the offer; sampled only while `dma_valid` is high.
- `dma_done` in 1: one-cycle pulse; the engine has finished filling the buffer.
- `dma_bytes` in 32: bytes written; valid while `dma_done` is high.
- `cpl_req` out 1: notification request to the completion writer.
- `cpl_ack` in 1: completion writer accepts `cpl_req`.
- `cpl_idx` out 1: index of the completed buffer; 0 = lbuf1, 1 = lbuf2.
- `cpl_bytes` out 32: bytes written into the completed buffer.
- `cpl_seq` out SEQ_W: sequence number of the completed buffer.
- `active_idx` out 1: index of the buffer expected or in service.

## Operation
- FSM states: IDLE, OFFER, BUSY, NOTIFY, RELEASE.
- **Index register `cur`:**
  - Reset value 0.
  - Toggles only on leaving RELEASE.
  - Drives `active_idx`.
- **IDLE:**
  - Watches only the enable selected by `cur`. The other buffer's enable is ignored, even if it is asserted earlier or in the same cycle.
  - On that enable being high, latch the matching address and length into `dma_addr`/`dma_len`.
  - If the latched length ≠ 0, go to OFFER.
  - If the length = 0, go directly to RELEASE: no DMA, no notification, no sequence increment.
- **OFFER:**
  - `dma_valid` = 1.
  - On `dma_ack`, go to BUSY.
  - `dma_addr`/`dma_len` are stable while `dma_valid` is high.
- **BUSY:**
  - Wait for `dma_done`.
  - On `dma_done`, latch `cpl_bytes` = min(`dma_bytes`, latched length) and go to NOTIFY.
  - A `dma_done` outside BUSY is ignored.
- **NOTIFY:**
  - `cpl_req` = 1, with `cpl_idx` = `cur` and `cpl_seq` = current counter value.
  - On `cpl_ack`, increment the sequence counter (wraps modulo 2^SEQ_W) and go to RELEASE.
- **RELEASE:**
  - Pulse `lbufN_dn` for exactly one cycle, where N = `cur`+1.
  - Toggle `cur` and return to IDLE.
- The host-control block drops `lbufN_en` one cycle after the `dn` pulse. Because `cur` has already moved on, the stale level cannot restart service.
- Changes to `lbufN_en`, address or length of the buffer in service between the IDLE latch and RELEASE are ignored.

## Timing
- **Reset values:**
  - `dma_valid`, `cpl_req`, `lbuf1_dn`, `lbuf2_dn` = 0.
  - `cur`, `active_idx`, `cpl_idx` = 0.
  - Sequence counter and `cpl_seq` = 0.
  - `dma_addr`, `dma_len`, `cpl_bytes` = 0.
  - FSM = IDLE.
- All outputs are registered.
- Enable sampled high in IDLE at edge t → `dma_valid` high from t+1.
- `dma_ack` at edge t → `dma_valid` low from t+1.
- `dma_done` at edge t → `cpl_req` high from t+1.
- `cpl_ack` at edge t → `dn` high during cycle t+1 only → IDLE at t+2.
- Zero-length buffer: enable at t → `dn` pulse at t+1.
- Minimum turnaround from done to the next offer, with the other enable already high and `cpl_ack` tied high: 4 cycles.
- `rst` asserted in any state aborts the operation within the same edge.
  - No `dn` or `cpl_req` is issued for the aborted buffer.
  - The scheduler restarts at lbuf1.
  - The host-control block is reset by the same `rst`.

## Structure
- A shared package, used by the host-control block, DMA engine and completion writer, holds:
  - the FSM state encoding (one-hot, 5 bits);
  - the buffer index constants `LBUF1_IDX` = 0 and `LBUF2_IDX` = 1;
  - the 64-bit address and 32-bit length widths.
- No sub-module, with one optional exception: a 2:1 buffer descriptor mux `lbuf_desc_mux` (combinational address/length select on `cur`).

## Test plan
- **Basic cycle:** lbuf1 (addr 0x0000_0001_0000_0000, len 0x1000) posted; ack after 2 cycles; done with bytes 0x800; `cpl_ack` immediate.
  - Offer shows the lbuf1 addr and len.
  - `cpl_idx` = 0, `cpl_bytes` = 0x800, `cpl_seq` = 0.
  - `lbuf1_dn` is a single pulse; `active_idx` becomes 1.
- **Ordering:** `lbuf2_en` raised 10 cycles before `lbuf1_en`.
  - No offer until `lbuf1_en`.
  - lbuf1 is served first, then lbuf2 immediately after; `cpl_seq` values are 0 then 1.
- **Clamp and zero length:** lbuf1 len 0x100 with `dma_bytes` 0x200, then lbuf2 len 0.
  - `cpl_bytes` = 0x100.
  - lbuf2 gets a `dn` pulse one cycle after enable, with no `dma_valid` and no `cpl_req`.
- **Back-pressure:** `dma_ack` held low for 50 cycles, then `cpl_ack` held low for 30 cycles.
  - `dma_valid`, address and length stay stable throughout the first stall.
  - `cpl_req`, `cpl_idx`, `cpl_bytes` and `cpl_seq` stay stable throughout the second stall.
  - No `dn` until after the ack.
- **Wrap and reset:** with SEQ_W = 2, run 5 buffers → `cpl_seq` values are 0,1,2,3,0. Then assert `rst` in BUSY:
  - all outputs return to reset values on the next cycle;
  - a subsequent `dma_done` is ignored;
  - the next buffer served is lbuf1.
